// File: rtl/direction_pkg.sv
// Shared types and helpers for the windowed direction accumulator.
package direction_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2,
        OUTPUT  = 2'd3
    } dir_state_t;

    // Locations are sign-extended into this fixed-width container before use.
    localparam int LOC_W_MAX = 32;
    localparam int SAT_W     = 64;

    typedef struct packed {
        logic signed [LOC_W_MAX-1:0] x;
        logic signed [LOC_W_MAX-1:0] y;
    } mic_location_t;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v)      return max_v;
        else if (value < min_v) return min_v;
        else                    return value;
    endfunction

endpackage

// File: rtl/amplitude_window.sv
// Per-channel |sample| accumulation over 2^WINDOW_LOG2 samples with window-close
// pulse and snapshot of the per-channel mean when capture is enabled.
module amplitude_window
    import direction_pkg::*;
#(
    parameter int NUM_MICS     = 3,
    parameter int SAMPLE_WIDTH = 32,
    parameter int WINDOW_LOG2  = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0]              central_mic_in,
    input  logic [NUM_MICS*SAMPLE_WIDTH-1:0]     peripheral_mics_in,
    input  logic                                 capture_en_in,
    output logic                                 window_close_out,
    output logic [(NUM_MICS+1)*SAMPLE_WIDTH-1:0] means_out
);

    localparam int NCH   = NUM_MICS + 1;
    localparam int ACC_W = SAMPLE_WIDTH + WINDOW_LOG2;

    // Channel NUM_MICS is the central mic; peripherals occupy 0..NUM_MICS-1.
    logic [NCH*SAMPLE_WIDTH-1:0]          w_samples;
    logic [SAMPLE_WIDTH-1:0]              w_raw   [NCH];
    logic [SAMPLE_WIDTH-1:0]              w_abs   [NCH];
    logic [ACC_W-1:0]                     w_total [NCH];
    logic [ACC_W-1:0]                     r_acc   [NCH];
    logic [WINDOW_LOG2-1:0]               r_count;
    logic [NCH*SAMPLE_WIDTH-1:0]          r_means;
    logic                                 w_close;

    assign w_samples = {central_mic_in, peripheral_mics_in};
    assign w_close   = sample_valid_in && (&r_count);

    // Unsigned negate maps the most-negative code onto 2^(SAMPLE_WIDTH-1).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_raw[i]   = w_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            w_abs[i]   = w_raw[i][SAMPLE_WIDTH-1] ? -w_raw[i] : w_raw[i];
            w_total[i] = r_acc[i] + ACC_W'(w_abs[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            r_count <= '0;
            r_means <= '0;
        end else if (sample_valid_in) begin
            r_count <= r_count + WINDOW_LOG2'(1);
            for (int i = 0; i < NCH; i++) begin
                if (w_close) begin
                    r_acc[i] <= '0;
                    if (capture_en_in)
                        r_means[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= w_total[i][ACC_W-1:WINDOW_LOG2];
                end else begin
                    r_acc[i] <= w_total[i];
                end
            end
        end
    end

    assign window_close_out = w_close;
    assign means_out        = r_means;

endmodule

// File: rtl/direction_accumulator.sv
// Windowed direction accumulator: location-weighted sum of mean amplitude
// differences, computed serially one mic per cycle, presented on valid/ready.
module direction_accumulator
    import direction_pkg::*;
#(
    parameter int NUM_MICS     = 3,
    parameter int SAMPLE_WIDTH = 32,
    parameter int LOC_WIDTH    = 16,
    parameter int WINDOW_LOG2  = 8,
    parameter int OUT_SHIFT    = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0]           central_mic_in,
    input  logic [NUM_MICS*SAMPLE_WIDTH-1:0]  peripheral_mics_in,
    input  logic [NUM_MICS*2*LOC_WIDTH-1:0]   mic_locations_in,
    output logic [2*LOC_WIDTH-1:0]            vector_out,
    output logic                              vector_valid_out,
    input  logic                              vector_ready_in,
    output logic                              busy_out,
    output logic [7:0]                        drop_count_out,
    output logic [1:0]                        state_dbg_out
);

    localparam int IDX_W  = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
    localparam int DIFF_W = SAMPLE_WIDTH + 1;
    localparam int SUM_W  = SAMPLE_WIDTH + 1 + LOC_WIDTH + $clog2(NUM_MICS);

    dir_state_t                        r_state;
    dir_state_t                        w_next_state;
    logic [IDX_W-1:0]                  r_idx;
    logic signed [SUM_W-1:0]           r_sum_x;
    logic signed [SUM_W-1:0]           r_sum_y;
    logic signed [SUM_W-1:0]           w_prod_x;
    logic signed [SUM_W-1:0]           w_prod_y;
    logic signed [SUM_W-1:0]           w_shx;
    logic signed [SUM_W-1:0]           w_shy;
    logic [LOC_WIDTH-1:0]              w_vec_x;
    logic [LOC_WIDTH-1:0]              w_vec_y;
    logic [SAMPLE_WIDTH-1:0]           w_mean_i;
    logic [SAMPLE_WIDTH-1:0]           w_mean_c;
    logic signed [DIFF_W-1:0]          w_diff;
    mic_location_t                     w_loc;
    logic [2*LOC_WIDTH-1:0]            r_vector;
    logic [7:0]                        r_drop;
    logic                              w_close;
    logic [(NUM_MICS+1)*SAMPLE_WIDTH-1:0] w_means;

    amplitude_window #(
        .NUM_MICS     (NUM_MICS),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .WINDOW_LOG2  (WINDOW_LOG2)
    ) u_window (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .sample_valid_in    (sample_valid_in),
        .central_mic_in     (central_mic_in),
        .peripheral_mics_in (peripheral_mics_in),
        .capture_en_in      (r_state == ACCUM),
        .window_close_out   (w_close),
        .means_out          (w_means)
    );

    // Mic i's location sits at [i*2*LOC_WIDTH +: 2*LOC_WIDTH] as {x, y}.
    always_comb begin
        w_mean_c = w_means[NUM_MICS*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        w_mean_i = w_means[int'(r_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        w_diff   = $signed({1'b0, w_mean_i}) - $signed({1'b0, w_mean_c});
        w_loc.x  = LOC_W_MAX'($signed(mic_locations_in[int'(r_idx)*2*LOC_WIDTH + LOC_WIDTH +: LOC_WIDTH]));
        w_loc.y  = LOC_W_MAX'($signed(mic_locations_in[int'(r_idx)*2*LOC_WIDTH +: LOC_WIDTH]));
        w_prod_x = SUM_W'(w_diff) * SUM_W'($signed(w_loc.x));
        w_prod_y = SUM_W'(w_diff) * SUM_W'($signed(w_loc.y));
    end

    assign w_shx   = r_sum_x >>> OUT_SHIFT;
    assign w_shy   = r_sum_y >>> OUT_SHIFT;
    assign w_vec_x = LOC_WIDTH'(sat_signed(SAT_W'(w_shx), LOC_WIDTH));
    assign w_vec_y = LOC_WIDTH'(sat_signed(SAT_W'(w_shy), LOC_WIDTH));

    // Output handshake: vector_valid_out holds with vector_out stable until a
    // cycle where vector_ready_in is also high; that edge completes the transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACCUM:   if (w_close) w_next_state = COMPUTE;
            COMPUTE: if (r_idx == IDX_W'(NUM_MICS - 1)) w_next_state = FINISH;
            FINISH:  w_next_state = OUTPUT;
            OUTPUT:  if (vector_ready_in) w_next_state = ACCUM;
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ACCUM;
        else           r_state <= w_next_state;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx    <= '0;
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_vector <= '0;
            r_drop   <= '0;
        end else begin
            case (r_state)
                ACCUM: if (w_close) begin
                    r_sum_x <= '0;
                    r_sum_y <= '0;
                    r_idx   <= '0;
                end
                COMPUTE: begin
                    r_sum_x <= r_sum_x + w_prod_x;
                    r_sum_y <= r_sum_y + w_prod_y;
                    r_idx   <= (r_idx == IDX_W'(NUM_MICS - 1)) ? '0 : r_idx + IDX_W'(1);
                end
                FINISH:  r_vector <= {w_vec_x, w_vec_y};
                default: ;
            endcase
            if (w_close && r_state != ACCUM && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
        end
    end

    assign vector_out       = r_vector;
    assign vector_valid_out = (r_state == OUTPUT);
    assign busy_out         = (r_state != ACCUM);
    assign drop_count_out   = r_drop;
    assign state_dbg_out    = r_state;

endmodule
